// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: Branch select codes,
// default vectors and the internal next-PC source encoding.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b011;
  localparam logic [2:0] SEL_JR  = 3'b111;

  localparam logic [31:0] DefResetVec = 32'h0000_3000;
  localparam logic [31:0] DefExcVec   = 32'h0000_4180;

  localparam int unsigned JIdxW = 26;

  // Where the next PC comes from once priorities are resolved.
  typedef enum logic [2:0] {
    SrcHold,
    SrcExc,
    SrcAddrErr,
    SrcEret,
    SrcPend,
    SrcTarget
  } pc_src_e;

  function automatic logic word_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-target calculation for SEQ, BR, J and JR selects.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]  pc_i,
  input  logic [2:0]       branch_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  address_i,
  input  logic [JIdxW-1:0] jump_target_i,
  input  logic [XLEN-1:0]  jr_target_i,
  output logic [XLEN-1:0]  target_o,
  output logic             redirect_o,
  output logic             misalign_o
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic [XLEN-1:0] seq_pc;

  assign seq_pc = pc_i + PcStep;

  always_comb begin
    target_o   = seq_pc;
    redirect_o = 1'b0;
    misalign_o = 1'b0;
    case (branch_i)
      SEL_BR: begin
        if (br_taken_i) begin
          target_o   = seq_pc + (address_i << 2);
          redirect_o = 1'b1;
        end
      end
      SEL_J: begin
        target_o   = {pc_i[XLEN-1:28], jump_target_i, 2'b00};
        redirect_o = 1'b1;
      end
      SEL_JR: begin
        target_o   = jr_target_i;
        // A misaligned JR is an exception, not a redirect.
        misalign_o = word_misaligned(jr_target_i[1:0]);
        redirect_o = ~misalign_o;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch PC, stall with buffered redirect, and
// precise exception entry/return (EPC, BadVAddr, in-exception flag).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DefResetVec),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DefExcVec)
) (
  input  logic             Clk,
  input  logic             PcReSet_n,
  input  logic             Stall,
  input  logic [2:0]       Branch,
  input  logic             BrTaken,
  input  logic [XLEN-1:0]  Address,
  input  logic [JIdxW-1:0] JumpTarget,
  input  logic [XLEN-1:0]  JrTarget,
  input  logic             ExcReq,
  input  logic [XLEN-1:0]  ExcPc,
  input  logic             Eret,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  Epc,
  output logic [XLEN-1:0]  BadVAddr,
  output logic             AddrErr,
  output logic             InExc,
  output logic             RedirPend
);

  if (XLEN < 32) begin : gen_bad_xlen
    $error("pc_gen: XLEN must be at least 32");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic            addr_err_q, addr_err_d;
  logic            in_exc_q, in_exc_d;

  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misalign;
  pc_src_e         src;

  pc_target_calc #(
    .XLEN (XLEN)
  ) u_target_calc (
    .pc_i          (pc_q),
    .branch_i      (Branch),
    .br_taken_i    (BrTaken),
    .address_i     (Address),
    .jump_target_i (JumpTarget),
    .jr_target_i   (JrTarget),
    .target_o      (target),
    .redirect_o    (redirect),
    .misalign_o    (misalign)
  );

  always_comb begin
    src = SrcHold;
    if (ExcReq) begin
      src = SrcExc;
    end else if (misalign) begin
      src = SrcAddrErr;
    end else if (Eret) begin
      src = SrcEret;
    end else if (!Stall && pend_vld_q) begin
      src = SrcPend;
    end else if (!Stall || redirect) begin
      src = SrcTarget;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    addr_err_d = 1'b0;
    in_exc_d   = in_exc_q;
    unique case (src)
      SrcExc, SrcAddrErr: begin
        pc_d       = EXC_VEC;
        pend_vld_d = 1'b0;
        // Nested exceptions keep the original return address.
        if (!in_exc_q) begin
          epc_d    = (src == SrcExc) ? ExcPc : pc_q;
          in_exc_d = 1'b1;
        end
        if (src == SrcAddrErr) begin
          badvaddr_d = JrTarget;
          addr_err_d = 1'b1;
        end
      end
      SrcEret: begin
        in_exc_d = 1'b0;
        if (Stall) begin
          pend_d     = epc_q;
          pend_vld_d = 1'b1;
        end else begin
          pc_d       = epc_q;
          pend_vld_d = 1'b0;
        end
      end
      SrcPend: begin
        pc_d       = pend_q;
        pend_vld_d = 1'b0;
      end
      SrcTarget: begin
        if (Stall) begin
          pend_d     = target;
          pend_vld_d = 1'b1;
        end else begin
          pc_d = target;
        end
      end
      SrcHold: ;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      addr_err_q <= 1'b0;
      in_exc_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      addr_err_q <= addr_err_d;
      in_exc_q   <= in_exc_d;
    end
  end

  assign PC        = pc_q;
  assign Epc       = epc_q;
  assign BadVAddr  = badvaddr_q;
  assign AddrErr   = addr_err_q;
  assign InExc     = in_exc_q;
  assign RedirPend = pend_vld_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS core, the successor to the fixed 32-bit PC block. Holds the fetch PC; computes sequential, branch, jump and jump-register targets; adds fetch stall with a buffered pending redirect; and supports precise exception entry/return (EPC, BadVAddr, in-exception flag). Sits between the decode/branch-resolve logic and instruction memory.

## Interface
- XLEN, 32, PC/data width; must be ≥ 32.
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- Clk  in  1  clock; all state updates on posedge.
- PcReSet_n  in  1  reset; asynchronous, active-low.
- Stall  in  1  fetch cannot accept a new PC; PC holds.
- Branch  in  3  redirect select: SEQ 3'b000, BR 3'b001, J 3'b011, JR 3'b111; other codes are treated as SEQ.
- BrTaken  in  1  conditional branch outcome; qualifies BR.
- Address  in  XLEN  sign-extended word offset for BR.
- JumpTarget  in  26  J-format instruction index.
- JrTarget  in  XLEN  register target for JR.
- ExcReq  in  1  take exception this cycle.
- ExcPc  in  XLEN  PC of the faulting instruction.
- Eret  in  1  return from exception.
- PC  out  XLEN  current fetch PC.
- Epc  out  XLEN  exception return address.
- BadVAddr  out  XLEN  last misaligned target.
- AddrErr  out  1  one-cycle pulse on misaligned JR.
- InExc  out  1  exception level flag.
- RedirPend  out  1  a redirect is buffered behind a stall.

## Operation
- Targets, all modulo 2^XLEN with wrap-around:
  - SEQ: PC+4.
  - BR: PC+4+(Address<<2) when BrTaken=1; otherwise PC+4.
  - J: {PC[XLEN-1:28], JumpTarget, 2'b00}.
  - JR: JrTarget.
- Priority, highest first: ExcReq, misaligned JR, Eret, pending redirect, Branch select, SEQ.
- ExcReq:
  - PC←EXC_VEC.
  - If InExc=0: Epc←ExcPc and InExc←1. If InExc=1, Epc is unchanged (nested exception).
  - Applied even while Stall=1; clears any pending redirect.
- Misaligned JR (Branch=JR with JrTarget[1:0]≠0):
  - Treated as an exception: BadVAddr←JrTarget, Epc←PC (subject to the InExc rule), PC←EXC_VEC, AddrErr=1 for one cycle.
  - Applied even while Stall=1.
- Eret: PC←Epc, InExc←0. Eret with InExc=0 still loads Epc.
- Stall=1, for any non-exception redirect (BR taken, J, JR, Eret):
  - PC holds.
  - The target is latched into the pending register, RedirPend←1.
  - A later redirect during the same stall overwrites the pending target.
- First cycle with Stall=0 and RedirPend=1: PC←pending target, RedirPend←0. Concurrent Branch inputs are ignored that cycle.
- Stall=1 with no redirect: PC and pending register hold.

## Timing
- Every output is registered; one-cycle latency from inputs to PC.
- Reset values: PC=RESET_VEC, Epc=0, BadVAddr=0, AddrErr=0, InExc=0, RedirPend=0, pending target=0.
- Reset asserted mid-operation discards the pending redirect immediately; it has no synchronous dependency.
- Simultaneous ExcReq and Eret: the exception wins and InExc stays 1.
- PC at 32'hFFFF_FFFC with SEQ wraps to 0.

## Structure
- pc_pkg holds the Branch select encodings (SEL_SEQ, SEL_BR, SEL_J, SEL_JR) and the default vector constants.
- One combinational sub-module, pc_target_calc. Inputs: PC, Branch, BrTaken, Address, JumpTarget, JrTarget. Outputs: the next target, a redirect flag and a misalign flag.
- pc_gen owns the PC, pending, Epc, BadVAddr and InExc registers and applies the priority order.

## Test plan
- Reset → PC=32'h0000_3000. Free-run SEQ for 3 cycles → 3004, 3008, 300C.
- PC=3010, BR, BrTaken=1, Address=32'hFFFF_FFFE → PC=300C. Same with BrTaken=0 → 3014.
- PC=3010, Stall=1, J with JumpTarget=26'h000_0400 → PC holds 3010 and RedirPend=1. Next cycle Stall=0 → PC=32'h0000_1000, RedirPend=0.
- JR with JrTarget=32'h0000_2002 → PC=EXC_VEC, BadVAddr=2002, AddrErr pulses 1 cycle, InExc=1.
- ExcReq with ExcPc=3020 → Epc=3020, InExc=1. Second ExcReq with ExcPc=3040 → Epc stays 3020. Eret → PC=3020, InExc=0.
- PcReSet_n low while RedirPend=1 → RedirPend=0 and PC=RESET_VEC immediately, before the next clock edge.
